chk_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one operand-check unit between NREQ requesters. The check unit is an 8-bit pair-compare/sum resource.
- Each requester offers an operand pair (a, b). The arbiter grants exactly one requester, latches its operands, and issues them to the check unit with a valid/ready handshake.
- It then waits for the unit's done/err result and routes that result back to the granted requester.
- Sits between the per-lane request logic and the single shared checker instance in the module.

---
 rtl/chk_rr_arbiter_if.sv | 33 +++
 rtl/chk_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_chk_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chk_rr_arbiter_if.sv
// Bundle of requester-side and check-unit-side signals for the
// round-robin check arbiter. The arbiter connects through the slave
// modport; the environment (requesters plus check unit) uses master.
interface chk_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   a_in;
  logic [NREQ*DW-1:0]   b_in;
  logic [NREQ-1:0]      gnt;
  logic                 chk_valid;
  logic [DW-1:0]        chk_a;
  logic [DW-1:0]        chk_b;
  logic                 chk_ready;
  logic                 chk_done;
  logic                 chk_err;
  logic [NREQ-1:0]      done_out;
  logic [NREQ-1:0]      err_out;
  logic                 busy;
  logic                 timeout;

  modport slave (
    input  en, req, a_in, b_in, chk_ready, chk_done, chk_err,
    output gnt, chk_valid, chk_a, chk_b, done_out, err_out, busy, timeout
  );

  modport master (
    output en, req, a_in, b_in, chk_ready, chk_done, chk_err,
    input  gnt, chk_valid, chk_a, chk_b, done_out, err_out, busy, timeout
  );
endinterface

// File: rtl/chk_rr_arbiter.sv
// Round-robin arbiter that shares one operand-check unit between NREQ
// requesters: grant one lane, latch and issue its operand pair, wait for
// the result (or a timeout) and route it back to the granted lane.
module chk_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TMO_MAX = 15
) (
  input logic             clk,
  input logic             rst,
  chk_rr_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(NREQ - 1);
  localparam logic [7:0]    TMO_LAST  = 8'(TMO_MAX - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   chkA_q, chkA_d;
  logic [DW-1:0]   chkB_q, chkB_d;
  logic [7:0]      tmoCnt_q, tmoCnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            timeout_q, timeout_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   nextPtr;

  // Pick the first requesting lane scanning upward from ptr with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign nextPtr = (sel_q == LAST_LANE) ? '0 : sel_q + 1'b1;

  // Sequencer: grant/latch in IDLE, hold operands in ISSUE, await result in WAIT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    chkA_d    = chkA_q;
    chkB_d    = chkB_q;
    tmoCnt_d  = tmoCnt_q;
    done_d    = '0;
    err_d     = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en && found) begin
          sel_d   = pick;
          gnt_d   = ONE_HOT0 << pick;
          chkA_d  = bus.a_in[pick*DW +: DW];
          chkB_d  = bus.b_in[pick*DW +: DW];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.chk_ready) begin
          valid_d  = 1'b0;
          tmoCnt_d = '0;
          if (bus.chk_done) begin
            done_d  = gnt_q;
            err_d   = bus.chk_err ? gnt_q : '0;
            ptr_d   = nextPtr;
            gnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tmoCnt_d = tmoCnt_q + 8'd1;
        if (bus.chk_done) begin
          done_d  = gnt_q;
          err_d   = bus.chk_err ? gnt_q : '0;
          ptr_d   = nextPtr;
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (tmoCnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          err_d     = gnt_q;
          ptr_d     = nextPtr;
          gnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset silently abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      chkA_q    <= '0;
      chkB_q    <= '0;
      tmoCnt_q  <= '0;
      done_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      chkA_q    <= chkA_d;
      chkB_q    <= chkB_d;
      tmoCnt_q  <= tmoCnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.chk_valid = valid_q;
  assign bus.chk_a     = chkA_q;
  assign bus.chk_b     = chkB_q;
  assign bus.done_out  = done_q;
  assign bus.err_out   = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_chk_rr_arbiter.sv
// Directed bench for chk_rr_arbiter: a per-cycle vector table covering
// single grants, round-robin order and result routing, followed by
// hand-written sequences for backpressure, timeout, enable and reset.
module tb_chk_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TMO_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  int   nCompared   = 0;
  int   nMismatched = 0;

  chk_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  chk_rr_arbiter #(.NREQ(NREQ), .DW(DW), .TMO_MAX(TMO_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       en, rdy, done, err;
    logic [3:0] expGnt;
    logic       expValid, expBusy;
    logic [3:0] expDone, expErr;
    logic       expTmo;
    logic [7:0] expA, expB;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic [3:0] req, input logic en, input logic rdy,
                              input logic done, input logic err, input logic [3:0] gnt,
                              input logic v, input logic bsy, input logic [3:0] dn,
                              input logic [3:0] er, input logic tmo, input logic [7:0] a,
                              input logic [7:0] b);
    vec_t r;
    r.req = req; r.en = en; r.rdy = rdy; r.done = done; r.err = err;
    r.expGnt = gnt; r.expValid = v; r.expBusy = bsy; r.expDone = dn;
    r.expErr = er; r.expTmo = tmo; r.expA = a; r.expB = b;
    return r;
  endfunction

  task automatic applyStimulus(input logic [3:0] req, input logic en, input logic rdy,
                               input logic done, input logic err);
    bus.req       = req;
    bus.en        = en;
    bus.chk_ready = rdy;
    bus.chk_done  = done;
    bus.chk_err   = err;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   cycles;
    logic seen;
    logic flag;

    bus.a_in = 32'h44_33_07_11;
    bus.b_in = 32'h88_77_03_55;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #12;
    checkOutput("reset gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset valid", 32'(bus.chk_valid), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset done", 32'(bus.done_out), 32'h0);
    checkOutput("reset err", 32'(bus.err_out), 32'h0);
    checkOutput("reset timeout", 32'(bus.timeout), 32'h0);
    checkOutput("reset chk_a", 32'(bus.chk_a), 32'h0);
    checkOutput("reset chk_b", 32'(bus.chk_b), 32'h0);
    tick();
    rst = 1'b1;

    //               req     en    rdy   done  err   gnt     v     bsy   done    err     tmo   a      b
    vecs[0]  = mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h07, 8'h03);
    vecs[1]  = mk(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[2]  = mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[3]  = mk(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[4]  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[5]  = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h33, 8'h77);
    vecs[6]  = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[7]  = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[8]  = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h44, 8'h88);
    vecs[9]  = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[10] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[11] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'h55);
    vecs[12] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[13] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[14] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h07, 8'h03);
    vecs[15] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[16] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[17] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h33, 8'h77);
    vecs[18] = mk(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[19] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[20] = mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h44, 8'h88);
    vecs[21] = mk(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'h00, 8'h00);
    vecs[22] = mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[23] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'h55);
    vecs[24] = mk(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h11, 8'h55);
    vecs[25] = mk(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[26] = mk(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h00, 8'h00);
    vecs[27] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].req, vecs[i].en, vecs[i].rdy, vecs[i].done, vecs[i].err);
      tick();
      checkOutput($sformatf("row%0d gnt", i), 32'(bus.gnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("row%0d valid", i), 32'(bus.chk_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d done", i), 32'(bus.done_out), 32'(vecs[i].expDone));
      checkOutput($sformatf("row%0d err", i), 32'(bus.err_out), 32'(vecs[i].expErr));
      checkOutput($sformatf("row%0d timeout", i), 32'(bus.timeout), 32'(vecs[i].expTmo));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("row%0d chk_a", i), 32'(bus.chk_a), 32'(vecs[i].expA));
        checkOutput($sformatf("row%0d chk_b", i), 32'(bus.chk_b), 32'(vecs[i].expB));
      end
    end

    // Backpressure on lane 1 (ptr=1); req dropped after grant has no effect.
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp grant", 32'(bus.gnt), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("bp%0d valid", c), 32'(bus.chk_valid), 32'h1);
      checkOutput($sformatf("bp%0d chk_a", c), 32'(bus.chk_a), 32'h07);
      checkOutput($sformatf("bp%0d chk_b", c), 32'(bus.chk_b), 32'h03);
      checkOutput($sformatf("bp%0d gnt", c), 32'(bus.gnt), 32'h2);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bp accept valid", 32'(bus.chk_valid), 32'h0);
    checkOutput("bp accept busy", 32'(bus.busy), 32'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("bp done", 32'(bus.done_out), 32'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Timeout on lane 2 (ptr=2): no chk_done ever.
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("tmo grant", 32'(bus.gnt), 32'h4);
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      tick();
      cycles++;
      if (bus.timeout) seen = 1'b1;
    end
    checkOutput("tmo seen", 32'(seen), 32'h1);
    checkOutput("tmo cycles", 32'(cycles), 32'(TMO_MAX));
    checkOutput("tmo err", 32'(bus.err_out), 32'h4);
    checkOutput("tmo done", 32'(bus.done_out), 32'h0);
    checkOutput("tmo gnt", 32'(bus.gnt), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("tmo pulse width", 32'(bus.timeout), 32'h0);
    checkOutput("tmo err width", 32'(bus.err_out), 32'h0);

    // Done exactly at the timeout limit on lane 3 (ptr=3).
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lim grant", 32'(bus.gnt), 32'h8);
    applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    flag = 1'b0;
    for (int c = 0; c < TMO_MAX - 1; c++) begin
      tick();
      if (bus.timeout || bus.done_out != 4'b0000) flag = 1'b1;
    end
    checkOutput("lim early event", 32'(flag), 32'h0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("lim done", 32'(bus.done_out), 32'h8);
    checkOutput("lim timeout", 32'(bus.timeout), 32'h0);
    checkOutput("lim err", 32'(bus.err_out), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Enable gating then done with error on lane 2 (ptr=0).
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.gnt != 4'b0000 || bus.busy) flag = 1'b1;
    end
    checkOutput("en0 no grant", 32'(flag), 32'h0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("en1 grant", 32'(bus.gnt), 32'h4);
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("en err done", 32'(bus.done_out), 32'h4);
    checkOutput("en err err", 32'(bus.err_out), 32'h4);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset during WAIT on lane 3 (ptr=3).
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst grant", 32'(bus.gnt), 32'h8);
    applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rst in wait", 32'(bus.busy), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rst async gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst async valid", 32'(bus.chk_valid), 32'h0);
    checkOutput("rst async busy", 32'(bus.busy), 32'h0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1, 1'b1);
    flag = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.done_out != 4'b0000 || bus.err_out != 4'b0000 || bus.timeout) flag = 1'b1;
    end
    checkOutput("rst silent", 32'(flag), 32'h0);
    rst = 1'b1;
    applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst ptr0 grant", 32'(bus.gnt), 32'h2);
    checkOutput("rst ptr0 chk_a", 32'(bus.chk_a), 32'h07);
    checkOutput("rst silent done", 32'(bus.done_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
